y_sig_misr: RTL and testbench

Y_SIG_MISR -- requirements
Module: y_sig_misr

---
 rtl/y_sig_pkg.sv | 30 +++
 rtl/y_fold.sv | 31 +++
 rtl/y_sig_misr.sv | 99 +++++++++
 tb/tb_y_sig_misr.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/y_sig_pkg.sv
// ------------------------------------------------------------------
// y_sig_pkg : shared constants and state encoding for the y-bus MISR
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package y_sig_pkg;

  localparam int SIG_WIDTH = 32;
  localparam logic [SIG_WIDTH-1:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [SIG_WIDTH-1:0] DEFAULT_SEED = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [SIG_WIDTH-1:0] misr_step(
    input logic [SIG_WIDTH-1:0] s,
    input logic [SIG_WIDTH-1:0] poly,
    input logic [SIG_WIDTH-1:0] din
  );
    return {s[SIG_WIDTH-2:0], 1'b0} ^ (s[SIG_WIDTH-1] ? poly : '0) ^ din;
  endfunction

endpackage

`default_nettype wire

// File: rtl/y_fold.sv
// ------------------------------------------------------------------
// y_fold : XOR-folds a wide bus into one 32-bit word, top slice zero-padded
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module y_fold
  import y_sig_pkg::*;
#(
  parameter int Y_WIDTH = 1390
) (
  input  logic [Y_WIDTH-1:0]   i_y,
  output logic [SIG_WIDTH-1:0] o_fold
);

  localparam int C_NSLICE = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;

  logic [C_NSLICE*SIG_WIDTH-1:0] w_pad;

  always_comb begin
    w_pad              = '0;
    w_pad[Y_WIDTH-1:0] = i_y;
    o_fold             = '0;
    for (int i = 0; i < C_NSLICE; i++) begin
      o_fold = o_fold ^ w_pad[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

endmodule

`default_nettype wire

// File: rtl/y_sig_misr.sv
// ------------------------------------------------------------------
// y_sig_misr : captures N cycles of a wide y bus into a 32-bit MISR signature
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module y_sig_misr
  import y_sig_pkg::*;
#(
  parameter int                   Y_WIDTH = 1390,
  parameter logic [SIG_WIDTH-1:0] POLY    = DEFAULT_POLY,
  parameter logic [SIG_WIDTH-1:0] SEED    = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [Y_WIDTH-1:0]   y_in,
  input  logic                 start,
  input  logic [15:0]          num_cycles,
  output logic [SIG_WIDTH-1:0] sig,
  output logic                 busy,
  output logic                 done
);

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_accept;
  logic [SIG_WIDTH-1:0] w_fold;
  logic [SIG_WIDTH-1:0] r_sig;
  logic [SIG_WIDTH-1:0] r_fold_q;
  logic                 r_fold_v;
  logic [15:0]          r_count;

  y_fold #(
    .Y_WIDTH (Y_WIDTH)
  ) u_fold (
    .i_y    (y_in),
    .o_fold (w_fold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = (num_cycles != 16'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (r_count == 16'd1) begin
          w_next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: w_next_state = ST_DONE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // The fold is registered one cycle ahead of its MISR update; FLUSH drains the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig    <= SEED;
      r_fold_q <= '0;
      r_fold_v <= 1'b0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_sig    <= SEED;
      r_count  <= num_cycles;
      r_fold_v <= 1'b0;
    end else begin
      if (r_fold_v) begin
        r_sig <= misr_step(r_sig, POLY, r_fold_q);
      end
      if (r_state == ST_RUN) begin
        r_fold_q <= w_fold;
        r_fold_v <= 1'b1;
        r_count  <= r_count - 16'd1;
      end else if (r_state == ST_FLUSH) begin
        r_fold_v <= 1'b0;
      end
    end
  end

  assign sig  = r_sig;
  assign busy = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign done = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_y_sig_misr.sv
// ------------------------------------------------------------------
// tb_y_sig_misr : randomized self-checking bench with a software MISR model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_y_sig_misr;

  localparam int          YW     = 1390;
  localparam logic [31:0] POLY_C = 32'h04C11DB7;
  localparam logic [31:0] SEED_C = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [YW-1:0] y_in;
  logic          start;
  logic [15:0]   num_cycles;
  logic [31:0]   sig;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  y_sig_misr #(
    .Y_WIDTH (YW),
    .POLY    (POLY_C),
    .SEED    (SEED_C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y_in       (y_in),
    .start      (start),
    .num_cycles (num_cycles),
    .sig        (sig),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bit i of the bus lands on bit i mod 32 of the fold.
  function automatic logic [31:0] fold_ref(input logic [YW-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < YW; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] d);
    logic [31:0] nx;
    nx = s << 1;
    if (s[31]) nx = nx ^ POLY_C;
    return nx ^ d;
  endfunction

  // Reference model: edges since the accepted start, and the folded samples taken so far.
  logic        m_act = 1'b0;
  int          m_t   = 0;
  int          m_n   = 0;
  int          m_gen = 0;
  logic [31:0] m_folds [0:65535];
  logic        m_busy;

  assign m_busy = m_act && (m_n > 0) && (m_t <= m_n);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_t   <= 0;
      m_n   <= 0;
      m_gen <= m_gen + 1;
    end else if (start && !m_busy) begin
      m_act <= 1'b1;
      m_t   <= 0;
      m_n   <= int'(num_cycles);
      m_gen <= m_gen + 1;
    end else if (m_act && (m_t <= m_n)) begin
      m_t <= m_t + 1;
      if (m_t < m_n) m_folds[m_t] <= fold_ref(y_in);
    end
  end

  // Signature after t edges reflects the first t-1 samples, capped at N.
  initial begin
    logic [31:0] cs;
    int          cc;
    int          cg;
    int          want;
    cs = SEED_C;
    cc = 0;
    cg = -1;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cg != m_gen) begin
          cs = SEED_C;
          cc = 0;
          cg = m_gen;
        end
        if (!m_act || m_t == 0) want = 0;
        else if (m_t - 1 < m_n) want = m_t - 1;
        else want = m_n;
        while (cc < want) begin
          cs = misr_ref(cs, m_folds[cc]);
          cc++;
        end
        chk("sig_model", sig, cs);
        chk("busy_model", {31'd0, busy}, {31'd0, m_busy});
        chk("done_model", {31'd0, done}, {31'd0, m_act && !m_busy});
      end
    end
  end

  task automatic set_y(input int mode, input int bit_idx);
    logic [31:0] r;
    case (mode)
      0: y_in = '0;
      1: begin
        r = '0;
        for (int i = 0; i < YW; i++) begin
          if (i % 32 == 0) r = $urandom;
          y_in[i] = r[i % 32];
        end
      end
      2: begin
        y_in          = '0;
        y_in[bit_idx] = 1'b1;
      end
      default: y_in = {y_in[YW-2:0], y_in[YW-1]};
    endcase
  endtask

  // Called #1 after a rising edge; returns #1 after the edge where done is seen.
  task automatic do_run(input int n, input int mode, input int bit_idx, input bit repulse);
    int cnt;
    start      = 1'b1;
    num_cycles = 16'(n);
    set_y(mode, bit_idx);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (n > 0) begin
      chk("done_drop_on_start", {31'd0, done}, 32'd0);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
    end
    cnt = 0;
    while (!done && cnt < n + 10) begin
      set_y(mode, bit_idx);
      if (repulse && cnt == 1) begin
        start      = 1'b1;
        num_cycles = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cnt++;
    end
    start = 1'b0;
    chk("cycles_to_done", cnt, (n == 0) ? 0 : n + 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_cycles = '0;
    y_in       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sig", sig, SEED_C);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    do_run(1, 0, 0, 1'b0);
    chk("n1_zero_sig", sig, 32'hFB3EE249);
    do_run(1, 2, 0, 1'b0);
    chk("n1_bit0_sig", sig, 32'hFB3EE248);
    do_run(1, 2, 32, 1'b0);
    chk("n1_bit32_sig", sig, 32'hFB3EE248);
    do_run(1, 2, 1389, 1'b0);
    chk("n1_bit1389_sig", sig, 32'hFB3EC249);
    do_run(0, 1, 0, 1'b0);
    chk("n0_sig", sig, SEED_C);
    chk("n0_busy", {31'd0, busy}, 32'd0);
    do_run(4, 1, 0, 1'b1);

    start      = 1'b1;
    num_cycles = 16'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      set_y(1, 0);
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_sig", sig, SEED_C);
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      set_y(1, 0);
      @(posedge clk);
      #1;
      chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_idle_done", {31'd0, done}, 32'd0);
      chk("post_rst_idle_sig", sig, SEED_C);
    end

    repeat (3) do_run(1000, 1, 0, 1'b0);

    set_y(1, 0);
    do_run(65535, 3, 0, 1'b0);
    chk("n65535_done", {31'd0, done}, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
